// File: rtl/div_unit.sv
// ---------------------------------------------------------------------------
// div_unit
//   Iterative radix-2 restoring divider for MIPS DIV/DIVU in the execute
//   stage. One quotient bit is produced per cycle, so a divide holds the
//   pipeline for WIDTH+1 cycles, after which a one-cycle DONE state presents
//   {HI, LO} = {remainder, quotient}. An exception flush from the memory
//   stage abandons an in-flight divide without touching the last result.
//
// Ports:
//   clk              clock, all state updates on the rising edge
//   rst              synchronous active-high reset
//   div_startE       E-stage holds a valid DIV/DIVU
//   div_signedE      1 = DIV (two's complement), 0 = DIVU
//   srcaE            dividend (rs after forwarding)
//   srcbE            divisor  (rt after forwarding)
//   flush_exceptionM exception flush, cancels an in-flight divide
//   div_stallE       hold request to the hazard unit (combinational)
//   div_readyE       one-cycle pulse, result valid this cycle
//   div_resultE      {remainder, quotient} for the HI/LO write
// ---------------------------------------------------------------------------
module div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               div_startE,
  input  logic               div_signedE,
  input  logic [WIDTH-1:0]   srcaE,
  input  logic [WIDTH-1:0]   srcbE,
  input  logic               flush_exceptionM,
  output logic               div_stallE,
  output logic               div_readyE,
  output logic [2*WIDTH-1:0] div_resultE
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } stateT;

  stateT            state;
  logic [CW-1:0]    count;

  // Datapath registers: quoReg starts out holding the dividend magnitude and
  // is shifted left into remReg one bit per step while quotient bits fill in
  // from the bottom.
  logic [WIDTH-1:0] remReg;
  logic [WIDTH-1:0] quoReg;
  logic [WIDTH-1:0] divisorReg;
  logic             quoSign;
  logic             remSign;

  logic [WIDTH-1:0] absA;
  logic [WIDTH-1:0] absB;
  logic             divByZero;
  logic [WIDTH:0]   remShifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] nextRem;
  logic [WIDTH-1:0] nextQuo;
  logic [WIDTH-1:0] fixRem;
  logic [WIDTH-1:0] fixQuo;
  logic             startOk;

  // Operand magnitudes. Negating the most negative value wraps back to
  // itself, which read as unsigned is exactly 2^(WIDTH-1).
  always_comb begin
    absA      = (div_signedE && srcaE[WIDTH-1]) ? -srcaE : srcaE;
    absB      = (div_signedE && srcbE[WIDTH-1]) ? -srcbE : srcbE;
    divByZero = (srcbE == '0);
    startOk   = div_startE && !flush_exceptionM;
  end

  // One restoring step. The shifted remainder is always below 2*divisor, so
  // WIDTH+1 bits hold it and bit WIDTH of the difference is the borrow.
  always_comb begin
    remShifted = {remReg, quoReg[WIDTH-1]};
    trial      = remShifted - {1'b0, divisorReg};
    nextRem    = trial[WIDTH] ? remShifted[WIDTH-1:0] : trial[WIDTH-1:0];
    nextQuo    = {quoReg[WIDTH-2:0], ~trial[WIDTH]};
    fixQuo     = quoSign ? -nextQuo : nextQuo;
    fixRem     = remSign ? -nextRem : nextRem;
  end

  always_comb begin
    div_stallE = 1'b0;
    case (state)
      IDLE:    div_stallE = startOk;
      BUSY:    div_stallE = !flush_exceptionM;
      default: div_stallE = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      count       <= '0;
      div_readyE  <= 1'b0;
      div_resultE <= '0;
      remReg      <= '0;
      quoReg      <= '0;
      divisorReg  <= '0;
      quoSign     <= 1'b0;
      remSign     <= 1'b0;
    end else begin
      div_readyE <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (startOk) begin
            state      <= BUSY;
            remReg     <= '0;
            quoReg     <= absA;
            divisorReg <= absB;
            // A zero divisor leaves the quotient all ones and the remainder
            // equal to |dividend|; suppressing only the quotient fix-up and
            // keeping the remainder fix-up restores the original dividend.
            quoSign    <= div_signedE && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1])
                          && !divByZero;
            remSign    <= div_signedE && srcaE[WIDTH-1];
          end
        end
        BUSY: begin
          if (flush_exceptionM) begin
            state <= IDLE;
            count <= '0;
          end else begin
            remReg <= nextRem;
            quoReg <= nextQuo;
            count  <= count + CW'(1);
            if (count == CW'(WIDTH - 1)) begin
              state       <= DONE;
              div_readyE  <= 1'b1;
              div_resultE <= {fixRem, fixQuo};
            end
          end
        end
        DONE: begin
          state <= IDLE;
          count <= '0;
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the MIPS DIV/DIVU instructions, sitting in the execute stage.
- It is the producer of the execute-stage divide stall that the hazard unit consumes. While a divide is in flight it holds the pipeline, then delivers {HI, LO} = {remainder, quotient} for the HI/LO write.
- It honours exception flushes from the memory stage by abandoning the operation.

Parameters:
WIDTH, 32, operand width; also the iteration count

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous, active-high reset
div_startE  in  1  E-stage instruction is DIV/DIVU, valid, not bubble
div_signedE  in  1  1 = DIV (two's complement), 0 = DIVU
srcaE  in  WIDTH  dividend (rs value after forwarding)
srcbE  in  WIDTH  divisor (rt value after forwarding)
flush_exceptionM  in  1  exception flush; cancels an in-flight divide
div_stallE  out  1  pipeline hold request to the hazard unit
div_readyE  out  1  1-cycle pulse: result valid this cycle
div_resultE  out  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]} → {HI, LO}

Behaviour:
- States: IDLE, BUSY, DONE.
- Reset: state=IDLE, counter=0, div_readyE=0, div_resultE=0, div_stallE=0. Reset is sampled every cycle and overrides all else, including mid-BUSY (next state IDLE, result cleared).
- div_stallE (combinational):
  - IDLE: high when div_startE & ~flush_exceptionM.
  - BUSY: high unless flush_exceptionM.
  - DONE: low.
- IDLE → BUSY: on div_startE & ~flush_exceptionM.
  - Latch |srcaE| and |srcbE| (absolute values only when div_signedE).
  - Latch quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB] (signed only).
  - Latch a divide-by-zero flag. Clear the partial remainder; counter=0.
- BUSY step, each cycle:
  - Shift {rem, quo} left 1.
  - Compute trial = rem_shifted - divisor, at WIDTH+1 bits.
  - If trial is non-negative: rem = trial and quo LSB = 1; else keep rem and set quo LSB = 0.
  - Counter increments. After the WIDTH-th step (counter == WIDTH-1 at the edge) → DONE.
- DONE, exactly 1 cycle:
  - div_readyE=1. div_resultE is registered on entering DONE.
  - Sign fix-up: negate quo if quotient sign set; negate rem if remainder sign set.
  - Next state IDLE unconditionally. The same E instruction advances at this edge, so it is not restarted.
- Latency: start seen in cycle 0. div_stallE is high for cycles 0..WIDTH (33 cycles at WIDTH=32). Cycle WIDTH+1 is DONE, with the stall low and the result valid.
- Back-to-back divides: a second div_startE in the cycle after DONE starts a new operation normally.
- div_resultE holds its last value until the next DONE; it is cleared only by rst.
- div_readyE is 0 outside DONE.
- Divide by zero (architecturally undefined; fixed here): quotient = all ones, remainder = dividend, with no sign fix-up. No exception is raised.
- Signed overflow, most negative value / -1: quotient = most negative value, remainder = 0. The natural result of magnitude arithmetic with wrap-around meets this; no special case is needed.
- Width rules:
  - Negation is two's complement at WIDTH bits.
  - |most negative value| is handled as the unsigned value 2^(WIDTH-1).
  - The trial subtraction uses WIDTH+1 bits.
- flush_exceptionM:
  - In IDLE or BUSY: next state IDLE, counter cleared, div_readyE stays 0, div_resultE unchanged, div_stallE low in that same cycle.
  - In DONE: the result is still registered and the state returns to IDLE; no side effect, since the hazard unit flushes the stage.
- Simultaneous div_startE and flush_exceptionM in IDLE: flush wins; no start.
- srcaE, srcbE and div_signedE are ignored outside the IDLE-start cycle. Changes while BUSY have no effect.

Test Plan:
- DIVU 100 / 7 → div_stallE high exactly 33 consecutive cycles, then div_readyE for 1 cycle with div_resultE = {32'd2, 32'd14}; state back to IDLE.
- DIV -7 / 2 (0xFFFFFFF9 / 0x2) → div_resultE = {0xFFFFFFFF, 0xFFFFFFFD}. DIV 7 / -2 → {0x00000001, 0xFFFFFFFD}.
- DIV 0x80000000 / 0xFFFFFFFF → {0x00000000, 0x80000000}. DIVU 0x80000000 / 0xFFFFFFFF → {0x80000000, 0x00000000}.
- DIVU 5 / 0 → {0x00000005, 0xFFFFFFFF}, 33-cycle stall unchanged.
- Start DIVU, assert flush_exceptionM at BUSY cycle 10 → div_stallE low that cycle, no div_readyE pulse, div_resultE keeps its previous value. A new DIVU 9 / 3 next cycle → {0, 3} after 33 stall cycles.
- Two back-to-back DIVU (10/3 then 20/6) with rst pulsed for 1 cycle during the second's BUSY → first gives {1, 3}; after rst, outputs are all zero and state is IDLE. With srcaE/srcbE changed mid-BUSY on a fresh 20/6 → still {2, 3}.
